signed_add_accumulate: RTL and testbench

Parametrised, registered successor to the team's combinational signed two-operand adder. It accepts a stream of signed operand pairs over a valid/ready handshake. Per beat it performs add, subtract, accumulate or accumulate-restart, then returns a registered result with overflow indication. Overflow handling is selectable: saturate or wrap. It sits between arithmetic datapath producers and consumers that need back-pressure.

---
 rtl/signed_add_accumulate.sv | 131 +++++++++++++
 tb/tb_signed_add_accumulate.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/signed_add_accumulate.sv
// Registered signed add/subtract/accumulate stage with a valid/ready stream
// on both sides. Each accepted beat produces one result: the exact sum is
// formed two bits wider than the output. It is then reduced to OUT_WIDTH by
// clamping (SATURATE=1) or by two's-complement wrap (SATURATE=0). out_ovf
// flags every result whose reduced value differs from the exact sum.
//
// Handshake (both sides): a beat moves on a rising clk edge when valid and
// ready are both high. The producer holds valid and its payload until that
// edge. in_ready never depends on in_valid. out_valid/out_data/out_ovf stay
// stable while out_ready is low.
module signed_add_accumulate #(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 5,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_a,
  input  logic [IN_WIDTH-1:0]  in_b,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovf
);

  // The result must be able to hold a full a+b or a-b without loss.
  generate
    if (OUT_WIDTH < IN_WIDTH + 1) begin : g_width_check
      $error("signed_add_accumulate: OUT_WIDTH must be >= IN_WIDTH+1");
    end
  endgenerate

  // Two guard bits cover acc + a + b without loss.
  localparam int SW   = OUT_WIDTH + 2;
  localparam int MAXI = (2 ** (OUT_WIDTH - 1)) - 1;
  localparam logic signed [SW-1:0] MAX_V = SW'(MAXI);
  localparam logic signed [SW-1:0] MIN_V = SW'(-MAXI - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;

  logic                 xfer;
  logic signed [SW-1:0] a_ext, b_ext, acc_ext;
  logic signed [SW-1:0] exact;
  logic [OUT_WIDTH-1:0] reduced;
  logic                 ovf;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  assign a_ext   = {{(SW - IN_WIDTH){in_a[IN_WIDTH-1]}}, in_a};
  assign b_ext   = {{(SW - IN_WIDTH){in_b[IN_WIDTH-1]}}, in_b};
  assign acc_ext = {{2{acc_q[OUT_WIDTH-1]}}, acc_q};

  // Exact wide sum for the requested operation.
  always_comb begin
    exact = a_ext + b_ext;
    case (in_op)
      OP_ADD:  exact = a_ext + b_ext;
      OP_SUB:  exact = a_ext - b_ext;
      OP_ACC:  exact = acc_ext + a_ext + b_ext;
      OP_CLR:  exact = a_ext + b_ext;
      default: exact = a_ext + b_ext;
    endcase
  end

  // Reduce the exact sum to OUT_WIDTH and flag any loss of value.
  always_comb begin
    reduced = exact[OUT_WIDTH-1:0];
    ovf     = 1'b0;
    if (SATURATE) begin
      if (exact > MAX_V) begin
        reduced = MAX_V[OUT_WIDTH-1:0];
        ovf     = 1'b1;
      end else if (exact < MIN_V) begin
        reduced = MIN_V[OUT_WIDTH-1:0];
        ovf     = 1'b1;
      end
    end else begin
      ovf = ({{2{reduced[OUT_WIDTH-1]}}, reduced} != exact);
    end
  end

  // Next-state: load on a transfer, drop valid on a bare output handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = reduced;
      out_ovf_d   = ovf;
      if (in_op == OP_ACC || in_op == OP_CLR) begin
        acc_d = reduced;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset clears the held result and the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_signed_add_accumulate.sv
// Directed bench for signed_add_accumulate. Two instances share all inputs:
// one saturating, one wrapping, so each vector checks both reductions.
module tb_signed_add_accumulate;

  localparam int IW = 3;
  localparam int OW = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [IW-1:0] in_a;
  logic [IW-1:0] in_b;
  logic [1:0]    in_op;
  logic          out_ready;

  logic          s_in_ready, s_out_valid, s_out_ovf;
  logic [OW-1:0] s_out_data;
  logic          w_in_ready, w_out_valid, w_out_ovf;
  logic [OW-1:0] w_out_data;

  int tests;
  int fails;

  // ---------------- clock and reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  signed_add_accumulate #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf)
  );

  signed_add_accumulate #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_ovf(w_out_ovf)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sd(input logic [OW-1:0] v);
    return int'($signed(v));
  endfunction

  // Check both instances' output registers against expected values.
  task automatic chk_out(input string tag, input int vld, input int s_d, input int s_o,
                         input int w_d, input int w_o);
    chk({tag, ".sat.valid"}, int'(s_out_valid), vld);
    chk({tag, ".sat.data"},  sd(s_out_data),    s_d);
    chk({tag, ".sat.ovf"},   int'(s_out_ovf),   s_o);
    chk({tag, ".wrap.valid"}, int'(w_out_valid), vld);
    chk({tag, ".wrap.data"},  sd(w_out_data),    w_d);
    chk({tag, ".wrap.ovf"},   int'(w_out_ovf),   w_o);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] op, input int a, input int b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = IW'(a);
    in_b     = IW'(b);
  endtask

  // Offer one beat, let it transfer on the next edge, then idle the input.
  task automatic send(input logic [1:0] op, input int a, input int b);
    drive(op, a, b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(OP_ADD, 3, 3);

    // Reset held for three edges with a beat offered: nothing may appear.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_out($sformatf("reset%0d", i), 0, 0, 0, 0, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("reset.in_ready.sat", int'(s_in_ready), 1);
    chk("reset.in_ready.wrap", int'(w_in_ready), 1);

    // ADD then SUB back to back; out_valid stays high between them.
    send(OP_ADD, 3, 3);
    chk_out("add_3_3", 1, 6, 0, 6, 0);
    send(OP_SUB, -4, 3);
    chk_out("sub_m4_3", 1, -7, 0, -7, 0);
    send(OP_SUB, -4, -4);
    chk_out("sub_m4_m4", 1, 0, 0, 0, 0);

    // Output handshake with no new beat: valid drops, payload is kept.
    idle_cycle();
    chk_out("drain", 0, 0, 0, 0, 0);

    // Accumulation: saturate gives 6,12,15,7 and wrap gives 6,12,-14,10.
    send(OP_CLR, 3, 3);
    chk_out("clr_3_3", 1, 6, 0, 6, 0);
    send(OP_ACC, 3, 3);
    chk_out("acc1", 1, 12, 0, 12, 0);
    send(OP_ACC, 3, 3);
    chk_out("acc2", 1, 15, 1, -14, 1);
    send(OP_ACC, -4, -4);
    chk_out("acc3", 1, 7, 0, 10, 1);
    // ADD leaves the accumulator alone; the next ACC builds on 7 / 10.
    send(OP_ADD, -4, -4);
    chk_out("add_m4_m4", 1, -8, 0, -8, 0);
    send(OP_ACC, 1, 1);
    chk_out("acc_after_add", 1, 9, 0, 12, 0);
    // Negative clamp: -16 is exactly representable, -18 is not.
    send(OP_CLR, -4, -4);
    chk_out("clr_m4_m4", 1, -8, 0, -8, 0);
    send(OP_ACC, -4, -4);
    chk_out("acc_neg_edge", 1, -16, 0, -16, 0);
    send(OP_ACC, -1, -1);
    chk_out("acc_neg_sat", 1, -16, 1, 14, 1);

    // Back-pressure: result 6 held while an ACC(1,1) beat waits.
    send(OP_CLR, 3, 3);
    chk_out("bp_clr", 1, 6, 0, 6, 0);
    out_ready = 1'b0;
    drive(OP_ACC, 1, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.in_ready", i), int'(s_in_ready), 0);
      chk_out($sformatf("bp%0d", i), 1, 6, 0, 6, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", int'(s_in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("bp_acc", 1, 8, 0, 8, 0);

    // Asynchronous reset pulse between edges mid-accumulation.
    send(OP_CLR, 3, 3);
    send(OP_ACC, 3, 3);
    chk_out("pre_rst", 1, 12, 0, 12, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    send(OP_ACC, 1, 1);
    chk_out("acc_after_rst", 1, 2, 0, 2, 0);

    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
